spi_device: RTL

SPI_DEVICE -- requirements
Module: spi_device

---
 rtl/spi_device.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_device.sv
// SPI peripheral, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
// SCK, CS and COPI are oversampled in clk_i through synchronisers; SCK
// must run at clk_i/8 or slower.
//
// state  | meaning
// IDLE   | chip select inactive, SCK ignored, CIPO pad released
// ACTIVE | chip select active, shifting bytes on synchronised SCK edges
module spi_device #(
    parameter logic [7:0] TxIdleByte = 8'hFF,
    parameter int         SyncStages = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck_i,
    input  logic       cs_ni,
    input  logic       copi_i,
    output logic       cipo_o,
    output logic       cipo_en_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       busy_o,
    output logic       tx_underrun_o,
    output logic       rx_overrun_o,
    input  logic       clear_err_i
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SyncStages-1:0] sck_sync, cs_sync, copi_sync;
    logic sck_s, cs_s, copi_s;
    logic sck_prev, cs_prev;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    // After reset the chip-select synchroniser holds a forced 1; until it has
    // flushed and shown a real high level, a low cs_ni must not start a frame.
    logic [4:0] settle_cnt;
    logic       cs_armed;

    logic [2:0] bit_cnt;
    logic [7:0] tx_shift, rx_shift;
    logic       byte_seen;
    logic       rx_done;

    logic [7:0] tx_hold;
    logic       tx_full;
    logic       rx_valid_q;
    logic [7:0] rx_hold;

    logic start, in_active, sck_rise_act, sck_fall_act;
    logic reload, tx_accept, rx_pop;
    logic underrun_set, overrun_set;
    logic [7:0] tx_next;

    // Input synchronisers and edge-detect history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            copi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sck_sync[0]  <= sck_i;
            cs_sync[0]   <= cs_ni;
            copi_sync[0] <= copi_i;
            for (int i = 1; i < SyncStages; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
                copi_sync[i] <= copi_sync[i-1];
            end
            sck_prev <= sck_s;
            cs_prev  <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SyncStages-1];
    assign cs_s     = cs_sync[SyncStages-1];
    assign copi_s   = copi_sync[SyncStages-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    // Post-reset settle timer; arms frame start once CS is seen high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            settle_cnt <= 5'(SyncStages);
            cs_armed   <= 1'b0;
        end else begin
            if (settle_cnt != 5'd0) begin
                settle_cnt <= settle_cnt - 5'd1;
            end
            if (settle_cnt == 5'd0 && cs_s) begin
                cs_armed <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and per-cycle event decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall && cs_armed) state_d = ACTIVE;
            ACTIVE:  if (cs_rise)             state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign start        = (state_q == IDLE) && (state_d == ACTIVE);
    assign in_active    = (state_q == ACTIVE) && !cs_rise;
    assign sck_rise_act = in_active && sck_rise;
    assign sck_fall_act = in_active && sck_fall;
    assign reload       = start || (sck_fall_act && bit_cnt == 3'd0 && byte_seen);
    assign tx_next      = tx_full ? tx_hold : TxIdleByte;
    assign tx_accept    = tx_valid_i && !tx_full;
    assign rx_pop       = rx_valid_q && rx_ready_i;
    assign underrun_set = reload && !tx_full;
    assign overrun_set  = rx_done && rx_valid_q && !rx_ready_i;

    // Shift registers and bit counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt   <= 3'd0;
            tx_shift  <= 8'h00;
            rx_shift  <= 8'h00;
            byte_seen <= 1'b0;
            rx_done   <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (start) begin
                bit_cnt   <= 3'd0;
                byte_seen <= 1'b0;
                tx_shift  <= tx_next;
            end else if (sck_rise_act) begin
                rx_shift <= {rx_shift[6:0], copi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_done   <= 1'b1;
                    byte_seen <= 1'b1;
                end
            end else if (sck_fall_act) begin
                if (bit_cnt != 3'd0) begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end else if (byte_seen) begin
                    tx_shift <= tx_next;
                end
            end
            // A frame cut short mid-byte leaves nothing behind.
            if (state_q == ACTIVE && cs_rise) begin
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
            end
        end
    end

    // Transmit holding register; a reload and an accept may share a cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_full <= 1'b0;
            tx_hold <= 8'h00;
        end else begin
            if (reload && tx_full) begin
                tx_full <= 1'b0;
            end
            if (tx_accept) begin
                tx_full <= 1'b1;
                tx_hold <= tx_data_i;
            end
        end
    end

    // Receive holding register; a completing byte beats a same-cycle pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_valid_q <= 1'b0;
            rx_hold    <= 8'h00;
        end else if (rx_done && (!rx_valid_q || rx_pop)) begin
            rx_valid_q <= 1'b1;
            rx_hold    <= rx_shift;
        end else if (rx_pop) begin
            rx_valid_q <= 1'b0;
        end
    end

    // Sticky error flags; a set in the clearing cycle wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_underrun_o <= 1'b0;
            rx_overrun_o  <= 1'b0;
        end else begin
            if (underrun_set)     tx_underrun_o <= 1'b1;
            else if (clear_err_i) tx_underrun_o <= 1'b0;
            if (overrun_set)      rx_overrun_o  <= 1'b1;
            else if (clear_err_i) rx_overrun_o  <= 1'b0;
        end
    end

    assign busy_o     = (state_q == ACTIVE);
    assign cipo_en_o  = (state_q == ACTIVE);
    assign cipo_o     = (state_q == ACTIVE) ? tx_shift[7] : 1'b1;
    assign tx_ready_o = !tx_full;
    assign rx_data_o  = rx_hold;
    assign rx_valid_o = rx_valid_q;

endmodule
